// File: rtl/xgmii_tx_encoder.sv
// 64b/66b transmit encoder: pairs 32-bit XGMII beats into blocks, classifies and sequences them.
// Optional payload scrambler (1+x^39+x^58) enabled by defining XGMII_TX_SCRAMBLER_EN.
//
// state | meaning
// TX_C  | between frames; expecting IDLE or S
// TX_D  | inside a frame; expecting D or T
module xgmii_tx_encoder #(
   parameter int XGMII_DATA_WIDTH = 32,
   parameter int XGMII_CTRL_WIDTH = 4
) (
   input  logic                        i_clk,
   input  logic                        i_resent_n,
   input  logic [XGMII_DATA_WIDTH-1:0] i_xgmii_txd,
   input  logic [XGMII_CTRL_WIDTH-1:0] i_xgmii_ctrl,
   input  logic                        i_xgmii_valid,
   output logic [63:0]                 o_tx_payload,
   output logic [1:0]                  o_tx_hdr,
   output logic                        o_tx_valid,
   output logic [15:0]                 o_err_cnt
);

   typedef enum logic {TX_C, TX_D} state_t;
   typedef enum logic [2:0] {BLK_D, BLK_IDLE, BLK_S, BLK_T, BLK_E} blk_t;

   localparam logic [63:0] E_PAYLOAD = {{8{7'h1E}}, 8'h1E};

   state_t                        state, state_nxt;
   logic                          half;
   logic [XGMII_DATA_WIDTH-1:0]   lo_data;
   logic [XGMII_CTRL_WIDTH-1:0]   lo_ctrl;

   logic [63:0] blk_data;
   logic [7:0]  blk_ctrl;
   blk_t        blk_cls;
   logic [2:0]  term_n;
   logic [63:0] term_payload;
   logic        term_ok;
   logic [63:0] enc_payload;
   logic [1:0]  enc_hdr;
   logic        enc_err;
   logic [63:0] out_payload;
   logic        accept;

   assign accept   = i_xgmii_valid && half;
   assign blk_data = {i_xgmii_txd, lo_data};
   assign blk_ctrl = {i_xgmii_ctrl, lo_ctrl};

   always_comb begin
      blk_cls      = BLK_E;
      term_n       = 3'd0;
      term_ok      = 1'b0;
      term_payload = 64'd0;
      if (blk_ctrl == 8'h00) begin
         blk_cls = BLK_D;
      end else if (blk_ctrl == 8'hFF && blk_data == {8{8'h07}}) begin
         blk_cls = BLK_IDLE;
      end else if (blk_ctrl == 8'h01 && blk_data[7:0] == 8'hFB) begin
         blk_cls = BLK_S;
      end else begin
         for (int n = 0; n < 8; n++) begin
            term_ok = (blk_ctrl == 8'(8'hFF << n)) && (blk_data[8*n +: 8] == 8'hFD);
            for (int k = 0; k < 8; k++) begin
               if (k > n && blk_data[8*k +: 8] != 8'h07) term_ok = 1'b0;
            end
            if (term_ok) begin
               blk_cls = BLK_T;
               term_n  = 3'(n);
            end
         end
      end
      case (term_n)
         3'd0:    term_payload[7:0] = 8'h87;
         3'd1:    term_payload[7:0] = 8'h99;
         3'd2:    term_payload[7:0] = 8'hAA;
         3'd3:    term_payload[7:0] = 8'hB4;
         3'd4:    term_payload[7:0] = 8'hCC;
         3'd5:    term_payload[7:0] = 8'hD2;
         3'd6:    term_payload[7:0] = 8'hE1;
         default: term_payload[7:0] = 8'hFF;
      endcase
      for (int k = 0; k < 7; k++) begin
         if (k < int'(term_n)) term_payload[8+8*k +: 8] = blk_data[8*k +: 8];
      end
   end

   always_comb begin
      state_nxt   = state;
      enc_payload = E_PAYLOAD;
      enc_hdr     = 2'b10;
      enc_err     = 1'b1;
      case (state)
         TX_C: begin
            if (blk_cls == BLK_IDLE) begin
               enc_payload = 64'h1E;
               enc_err     = 1'b0;
            end else if (blk_cls == BLK_S) begin
               enc_payload = {blk_data[63:8], 8'h78};
               enc_err     = 1'b0;
               state_nxt   = TX_D;
            end
         end
         default: begin
            if (blk_cls == BLK_D) begin
               enc_payload = blk_data;
               enc_hdr     = 2'b01;
               enc_err     = 1'b0;
            end else if (blk_cls == BLK_T) begin
               enc_payload = term_payload;
               enc_err     = 1'b0;
               state_nxt   = TX_C;
            end else begin
               state_nxt   = TX_C;
            end
         end
      endcase
   end

`ifdef XGMII_TX_SCRAMBLER_EN
   // scr_hist[57] is the most recently transmitted scrambled bit
   logic [57:0]  scr_state;
   logic [121:0] scr_hist;

   always_comb begin
      scr_hist = {64'd0, scr_state};
      for (int i = 0; i < 64; i++) begin
         scr_hist[58+i] = enc_payload[i] ^ scr_hist[58+i-39] ^ scr_hist[i];
      end
      out_payload = scr_hist[121:58];
   end

   always_ff @(posedge i_clk or negedge i_resent_n) begin
      if (!i_resent_n)  scr_state <= '1;
      else if (accept)  scr_state <= scr_hist[121:64];
   end
`else
   assign out_payload = enc_payload;
`endif

   always_ff @(posedge i_clk or negedge i_resent_n) begin
      if (!i_resent_n) begin
         state        <= TX_C;
         half         <= 1'b0;
         lo_data      <= '0;
         lo_ctrl      <= '0;
         o_tx_payload <= 64'd0;
         o_tx_hdr     <= 2'b10;
         o_tx_valid   <= 1'b0;
         o_err_cnt    <= 16'd0;
      end else begin
         o_tx_valid <= 1'b0;
         if (i_xgmii_valid && !half) begin
            lo_data <= i_xgmii_txd;
            lo_ctrl <= i_xgmii_ctrl;
            half    <= 1'b1;
         end else if (accept) begin
            half         <= 1'b0;
            state        <= state_nxt;
            o_tx_payload <= out_payload;
            o_tx_hdr     <= enc_hdr;
            o_tx_valid   <= 1'b1;
            if (enc_err && o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_xgmii_tx_encoder.sv
// Directed bench for xgmii_tx_encoder (default build, scrambler disabled).
module tb_xgmii_tx_encoder;

   logic        i_clk = 1'b0;
   logic        i_resent_n;
   logic [31:0] i_xgmii_txd;
   logic [3:0]  i_xgmii_ctrl;
   logic        i_xgmii_valid;
   logic [63:0] o_tx_payload;
   logic [1:0]  o_tx_hdr;
   logic        o_tx_valid;
   logic [15:0] o_err_cnt;

   int checks = 0;
   int errors = 0;

   xgmii_tx_encoder dut (
      .i_clk         (i_clk),
      .i_resent_n    (i_resent_n),
      .i_xgmii_txd   (i_xgmii_txd),
      .i_xgmii_ctrl  (i_xgmii_ctrl),
      .i_xgmii_valid (i_xgmii_valid),
      .o_tx_payload  (o_tx_payload),
      .o_tx_hdr      (o_tx_hdr),
      .o_tx_valid    (o_tx_valid),
      .o_err_cnt     (o_err_cnt)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] lo_d;
      logic [3:0]  lo_c;
      logic [31:0] hi_d;
      logic [3:0]  hi_c;
      logic [63:0] pay;
      logic [1:0]  hdr;
      logic [15:0] err;
   } vec_t;

   localparam logic [63:0] E_PAY = 64'h3C78F1E3C78F1E1E;

   vec_t vecs[18];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // drives one block; returns on the negedge where its output should be visible
   task automatic send_block(input logic [31:0] ld, input logic [3:0] lc,
                             input logic [31:0] hd, input logic [3:0] hc, input bit gap);
      @(negedge i_clk);
      i_xgmii_txd = ld; i_xgmii_ctrl = lc; i_xgmii_valid = 1'b1;
      @(negedge i_clk);
      i_xgmii_valid = 1'b0;
      check("no_valid_after_lo_beat", 64'(o_tx_valid), 64'd0);
      if (gap) begin
         i_xgmii_txd = 32'hDEADBEEF; i_xgmii_ctrl = 4'h5;
         @(negedge i_clk);
         check("no_valid_during_gap", 64'(o_tx_valid), 64'd0);
      end
      i_xgmii_txd = hd; i_xgmii_ctrl = hc; i_xgmii_valid = 1'b1;
      @(negedge i_clk);
      i_xgmii_valid = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{32'h07070707, 4'hF, 32'h07070707, 4'hF, 64'h000000000000001E, 2'b10, 16'd0};
      vecs[1]  = '{32'h07070707, 4'hF, 32'h07070707, 4'hF, 64'h000000000000001E, 2'b10, 16'd0};
      vecs[2]  = '{32'h555555FB, 4'h1, 32'hD5555555, 4'h0, 64'hD555555555555578, 2'b10, 16'd0};
      vecs[3]  = '{32'h04030201, 4'h0, 32'h08070605, 4'h0, 64'h0807060504030201, 2'b01, 16'd0};
      vecs[4]  = '{32'h44332211, 4'h0, 32'h070707FD, 4'hF, 64'h00000044332211CC, 2'b10, 16'd0};
      vecs[5]  = '{32'h04030201, 4'h0, 32'h08070605, 4'h0, E_PAY,               2'b10, 16'd1};
      vecs[6]  = '{32'h555555FB, 4'h1, 32'hD5555555, 4'h0, 64'hD555555555555578, 2'b10, 16'd1};
      vecs[7]  = '{32'h555555FB, 4'h1, 32'hD5555555, 4'h0, E_PAY,               2'b10, 16'd2};
      vecs[8]  = '{32'h07070707, 4'hF, 32'h07070707, 4'hF, 64'h000000000000001E, 2'b10, 16'd2};
      vecs[9]  = '{32'h555555FB, 4'h1, 32'hD5555555, 4'h0, 64'hD555555555555578, 2'b10, 16'd2};
      vecs[10] = '{32'h070707FD, 4'hF, 32'h07070707, 4'hF, 64'h0000000000000087, 2'b10, 16'd2};
      vecs[11] = '{32'h555555FB, 4'h1, 32'hD5555555, 4'h0, 64'hD555555555555578, 2'b10, 16'd2};
      vecs[12] = '{32'h04030201, 4'h0, 32'hFD070605, 4'h8, 64'h07060504030201FF, 2'b10, 16'd2};
      vecs[13] = '{32'h44332211, 4'h0, 32'h070707FD, 4'hF, E_PAY,               2'b10, 16'd3};
      vecs[14] = '{32'h07070707, 4'hF, 32'h070707FB, 4'h1, E_PAY,               2'b10, 16'd4};
      vecs[15] = '{32'h555555FB, 4'h1, 32'hD5555555, 4'h0, 64'hD555555555555578, 2'b10, 16'd4};
      vecs[16] = '{32'h07070707, 4'hF, 32'h07070707, 4'hF, E_PAY,               2'b10, 16'd5};
      vecs[17] = '{32'h070707FE, 4'hE, 32'h07070707, 4'hF, E_PAY,               2'b10, 16'd6};

      i_resent_n = 1'b0;
      i_xgmii_txd = '0; i_xgmii_ctrl = '0; i_xgmii_valid = 1'b0;
      repeat (3) @(negedge i_clk);
      check("reset_payload", o_tx_payload, 64'd0);
      check("reset_hdr",     64'(o_tx_hdr), 64'd2);
      check("reset_valid",   64'(o_tx_valid), 64'd0);
      check("reset_err_cnt", 64'(o_err_cnt), 64'd0);
      i_resent_n = 1'b1;
      @(negedge i_clk);

      for (int i = 0; i < 18; i++) begin
         send_block(vecs[i].lo_d, vecs[i].lo_c, vecs[i].hi_d, vecs[i].hi_c, (i % 3) == 1);
         check($sformatf("v%0d_valid", i),   64'(o_tx_valid), 64'd1);
         check($sformatf("v%0d_payload", i), o_tx_payload, vecs[i].pay);
         check($sformatf("v%0d_hdr", i),     64'(o_tx_hdr), 64'(vecs[i].hdr));
         check($sformatf("v%0d_err_cnt", i), 64'(o_err_cnt), 64'(vecs[i].err));
         @(negedge i_clk);
         check($sformatf("v%0d_valid_drop", i), 64'(o_tx_valid), 64'd0);
      end

      // reset between the two beats of a block, with a start lower half latched
      @(negedge i_clk);
      i_xgmii_txd = 32'h555555FB; i_xgmii_ctrl = 4'h1; i_xgmii_valid = 1'b1;
      @(negedge i_clk);
      i_xgmii_valid = 1'b0;
      i_resent_n = 1'b0;
      repeat (2) @(negedge i_clk);
      check("midrst_valid",   64'(o_tx_valid), 64'd0);
      check("midrst_err_cnt", 64'(o_err_cnt), 64'd0);
      check("midrst_payload", o_tx_payload, 64'd0);
      i_resent_n = 1'b1;
      @(negedge i_clk);
      check("midrst_release_valid", 64'(o_tx_valid), 64'd0);
      send_block(32'h07070707, 4'hF, 32'h07070707, 4'hF, 1'b0);
      check("fresh_valid",   64'(o_tx_valid), 64'd1);
      check("fresh_payload", o_tx_payload, 64'h000000000000001E);
      check("fresh_hdr",     64'(o_tx_hdr), 64'd2);
      check("fresh_err_cnt", 64'(o_err_cnt), 64'd0);

      // after the fresh reset the FSM is in TX_C, so a data block is an error
      send_block(32'h04030201, 4'h0, 32'h08070605, 4'h0, 1'b0);
      check("post_rst_d_payload", o_tx_payload, E_PAY);
      check("post_rst_d_err_cnt", 64'(o_err_cnt), 64'd1);
      @(negedge i_clk);
      check("post_rst_d_valid_drop", 64'(o_tx_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
